gpio_apb_arbiter: RTL and testbench

- Shares the single APB4 slave port of the GPIO peripheral between NUM_REQ independent requesters, e.g. the core's load/store path and a pattern/DMA engine.
- Accepts one register command per grant, round-robin.
- Sequences the APB4 SETUP/ACCESS phases, returns read data and an error flag to the granted requester, and aborts a hung transfer after a programmable timeout.

---
 rtl/gpio_apb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_gpio_apb_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_arbiter.sv
// gpio_apb_arbiter: round-robin arbiter that shares the GPIO APB4 slave port
// between NUM_REQ requesters. It accepts one command per grant, runs the
// SETUP/ACCESS phases, routes the completion back to the owner and aborts a
// transfer whose PREADY never arrives.
module gpio_apb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      m_psel,
  output logic                      m_penable,
  output logic                      m_pwrite,
  output logic [ADDR_W-1:0]         m_paddr,
  output logic [DATA_W-1:0]         m_pwdata,
  input  logic [DATA_W-1:0]         m_prdata,
  input  logic                      m_pready,
  input  logic                      m_pslverr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e               state_q,     state_d;
  logic [PTR_W-1:0]     ptr_q,       ptr_d;
  logic [PTR_W-1:0]     owner_q,     owner_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic                 psel_q,      psel_d;
  logic                 penable_q,   penable_d;
  logic                 pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0]    paddr_q,     paddr_d;
  logic [DATA_W-1:0]    pwdata_q,    pwdata_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q,   rsp_err_d;

  logic                 gnt_found;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 timeout_hit;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(idx);
      end
    end
  end

  // Accept handshake is combinational and only offered while IDLE.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic for the APB sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          pwrite_d = req_write[gnt_idx];
          paddr_d  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
          psel_d   = 1'b1;
          owner_d  = gnt_idx;
          ptr_d    = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (m_pready) begin
          if (!pwrite_q) rsp_rdata_d = m_prdata;
          rsp_err_d            = m_pslverr;
          rsp_valid_d[owner_q] = 1'b1;
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          state_d              = IDLE;
        end else if (timeout_hit) begin
          rsp_err_d            = 1'b1;
          rsp_rdata_d          = '0;
          rsp_valid_d[owner_q] = 1'b1;
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          state_d              = IDLE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transfer without a response.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign m_psel    = psel_q;
  assign m_penable = penable_q;
  assign m_pwrite  = pwrite_q;
  assign m_paddr   = paddr_q;
  assign m_pwdata  = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Directed bench for gpio_apb_arbiter with two requesters and TIMEOUT = 4.
module tb_gpio_apb_arbiter;

  localparam int NR = 2;
  localparam int AW = 4;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             m_psel;
  logic             m_penable;
  logic             m_pwrite;
  logic [AW-1:0]    m_paddr;
  logic [DW-1:0]    m_pwdata;
  logic [DW-1:0]    m_prdata;
  logic             m_pready;
  logic             m_pslverr;

  int n_checks = 0;
  int n_errors = 0;

  gpio_apb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k]          = v;
    req_write[k]          = w;
    req_addr[k*AW +: AW]  = a;
    req_wdata[k*DW +: DW] = d;
  endtask

  // Checks the APB bus phase: psel, penable, pwrite, paddr, pwdata.
  task automatic check_bus(input string tag, input logic sel, input logic en,
                           input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({tag, ".psel"},    32'(m_psel),    32'(sel));
    check({tag, ".penable"}, 32'(m_penable), 32'(en));
    check({tag, ".pwrite"},  32'(m_pwrite),  32'(wr));
    check({tag, ".paddr"},   32'(m_paddr),   32'(a));
    check({tag, ".pwdata"},  m_pwdata,       d);
  endtask

  initial begin
    int rem0;
    int rem1;
    int exp_g;
    logic [DW-1:0] exp_d;

    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    m_prdata  = 32'h0000_00A5;
    m_pready  = 1'b1;
    m_pslverr = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst.psel",      32'(m_psel),    0);
    check("rst.penable",   32'(m_penable), 0);
    check("rst.paddr",     32'(m_paddr),   0);
    check("rst.pwdata",    m_pwdata,       0);
    check("rst.rsp_valid", 32'(rsp_valid), 0);
    check("rst.rsp_rdata", rsp_rdata,      0);
    check("rst.rsp_err",   32'(rsp_err),   0);
    check("rst.ready_idle", 32'(req_ready), 0);

    // Single write, zero wait
    set_req(0, 1'b1, 1'b1, 4'h0, 32'h0000_0005);
    #1 check("wr.c0.ready", 32'(req_ready), 32'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 4'h0, 32'h0);
    check_bus("wr.c1", 1'b1, 1'b0, 1'b1, 4'h0, 32'h5);
    check("wr.c1.ready", 32'(req_ready), 0);
    tick();
    check_bus("wr.c2", 1'b1, 1'b1, 1'b1, 4'h0, 32'h5);
    check("wr.c2.rsp_valid", 32'(rsp_valid), 0);
    tick();
    check("wr.c3.rsp_valid", 32'(rsp_valid), 32'b01);
    check("wr.c3.rsp_err",   32'(rsp_err),   0);
    check("wr.c3.psel",      32'(m_psel),    0);
    tick();
    check("wr.c4.rsp_valid", 32'(rsp_valid), 0);

    // Read DATA register from requester 1
    set_req(1, 1'b1, 1'b0, 4'h4, 32'h0);
    #1 check("rd.c0.ready", 32'(req_ready), 32'b10);
    tick();
    set_req(1, 1'b0, 1'b0, 4'h4, 32'h0);
    check_bus("rd.c1", 1'b1, 1'b0, 1'b0, 4'h4, 32'h0);
    tick();
    check_bus("rd.c2", 1'b1, 1'b1, 1'b0, 4'h4, 32'h0);
    tick();
    check("rd.rsp_valid", 32'(rsp_valid), 32'b10);
    check("rd.rsp_rdata", rsp_rdata,      32'h0000_00A5);
    check("rd.rsp_err",   32'(rsp_err),   0);
    check("rd.pwrite",    32'(m_pwrite),  0);
    tick();

    // Contention: three writes each, grants alternate starting with 0
    rem0 = 3;
    rem1 = 3;
    for (int t = 0; t < 6; t++) begin
      exp_g = t % 2;
      set_req(0, rem0 > 0, 1'b1, 4'h0, 32'h100 + 32'(3 - rem0));
      set_req(1, rem1 > 0, 1'b1, 4'h4, 32'h200 + 32'(3 - rem1));
      #1 check($sformatf("rr.t%0d.ready", t), 32'(req_ready), (exp_g == 0) ? 32'b01 : 32'b10);
      if (t > 0)
        check($sformatf("rr.t%0d.rsp_valid", t), 32'(rsp_valid), (exp_g == 0) ? 32'b10 : 32'b01);
      tick();
      exp_d = (exp_g == 0) ? 32'h100 + 32'(3 - rem0) : 32'h200 + 32'(3 - rem1);
      check($sformatf("rr.t%0d.paddr", t),  32'(m_paddr), (exp_g == 0) ? 32'h0 : 32'h4);
      check($sformatf("rr.t%0d.pwdata", t), m_pwdata,     exp_d);
      if (exp_g == 0) rem0--; else rem1--;
      tick();
      tick();
    end
    set_req(0, 1'b0, 1'b0, 4'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 4'h0, 32'h0);
    #1 check("rr.last.rsp_valid", 32'(rsp_valid), 32'b10);
    check("rr.last.ready", 32'(req_ready), 0);
    tick();

    // Wait states then PSLVERR (pointer back at 0)
    set_req(0, 1'b1, 1'b1, 4'h4, 32'hDEAD_BEEF);
    #1 check("ws.ready", 32'(req_ready), 32'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 4'h0, 32'h0);
    m_pready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_bus($sformatf("ws.acc%0d", i), 1'b1, 1'b1, 1'b1, 4'h4, 32'hDEAD_BEEF);
      check($sformatf("ws.acc%0d.rsp_valid", i), 32'(rsp_valid), 0);
      tick();
    end
    check_bus("ws.acc3", 1'b1, 1'b1, 1'b1, 4'h4, 32'hDEAD_BEEF);
    m_pready  = 1'b1;
    m_pslverr = 1'b1;
    tick();
    m_pslverr = 1'b0;
    check("ws.rsp_valid", 32'(rsp_valid), 32'b01);
    check("ws.rsp_err",   32'(rsp_err),   1);
    check("ws.rdata_hold", rsp_rdata,     32'h0000_00A5);
    check("ws.psel",      32'(m_psel),    0);
    tick();

    // Timeout on requester 1 (pointer at 1), requester 0 queued behind it
    set_req(0, 1'b1, 1'b1, 4'h0, 32'h0000_0077);
    set_req(1, 1'b1, 1'b0, 4'h4, 32'h0);
    #1 check("to.ready", 32'(req_ready), 32'b10);
    tick();
    set_req(1, 1'b0, 1'b0, 4'h0, 32'h0);
    m_pready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to.acc%0d.psel", i), 32'(m_psel), 1);
      check($sformatf("to.acc%0d.rsp_valid", i), 32'(rsp_valid), 0);
      tick();
    end
    m_pready = 1'b1;
    check("to.psel",      32'(m_psel),    0);
    check("to.rsp_valid", 32'(rsp_valid), 32'b10);
    check("to.rsp_err",   32'(rsp_err),   1);
    check("to.rsp_rdata", rsp_rdata,      0);
    check("to.next_ready", 32'(req_ready), 32'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 4'h0, 32'h0);
    check_bus("to.next.setup", 1'b1, 1'b0, 1'b1, 4'h0, 32'h77);
    tick();
    tick();
    check("to.next.rsp_valid", 32'(rsp_valid), 32'b01);
    check("to.next.rsp_err",   32'(rsp_err),   0);
    tick();

    // Reset mid-ACCESS with requester 1 pending
    set_req(0, 1'b1, 1'b1, 4'h4, 32'h0000_0033);
    #1 check("rs.ready", 32'(req_ready), 32'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 4'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'h4, 32'h0);
    m_pready = 1'b0;
    tick();
    check("rs.in_access", 32'(m_penable), 1);
    tick();
    rst = 1'b1;
    tick();
    check("rs.psel",      32'(m_psel),    0);
    check("rs.penable",   32'(m_penable), 0);
    check("rs.rsp_valid", 32'(rsp_valid), 0);
    check("rs.paddr",     32'(m_paddr),   0);
    rst      = 1'b0;
    m_pready = 1'b1;
    #1 check("rs.ready1", 32'(req_ready), 32'b10);
    tick();
    set_req(1, 1'b0, 1'b0, 4'h0, 32'h0);
    check_bus("rs.setup", 1'b1, 1'b0, 1'b0, 4'h4, 32'h0);
    check("rs.no_late_rsp", 32'(rsp_valid), 0);
    tick();
    tick();
    check("rs.rsp_valid", 32'(rsp_valid), 32'b10);
    check("rs.rsp_rdata", rsp_rdata,      32'h0000_00A5);
    tick();

    // Reset restores the pointer to 0: after a req0 grant (pointer 1) and a
    // reset, simultaneous requests go to requester 0 first.
    set_req(0, 1'b1, 1'b1, 4'h0, 32'h1);
    tick();
    set_req(0, 1'b0, 1'b0, 4'h0, 32'h0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 4'h0, 32'h2);
    set_req(1, 1'b1, 1'b1, 4'h4, 32'h3);
    #1 check("ptr.after_rst", 32'(req_ready), 32'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 4'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 4'h0, 32'h0);
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
